fetch_queue: RTL and testbench



---
 rtl/fetch_queue.sv | 194 +++++++++++++++++++
 tb/tb_fetch_queue.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues up to MAX_OUT in-order requests on the inst_* bus
// and buffers responses in a DEPTH-entry FIFO toward decode; redirects flush everything.
`timescale 1ns/1ps
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         redirect,
    input  logic [31:0]                  redirect_pc,
    output logic                         inst_req,
    output logic [31:0]                  inst_addr,
    input  logic                         inst_addr_ok,
    input  logic [31:0]                  inst_rdata,
    input  logic                         inst_data_ok,
    output logic                         out_valid,
    output logic [31:0]                  out_pc,
    output logic [31:0]                  out_inst,
    input  logic                         out_ready,
    output logic [$clog2(MAX_OUT+1)-1:0] inflight
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IF_W  = $clog2(MAX_OUT + 1);
    localparam int SUM_W = CNT_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [31:0]      stale_addr_q, stale_addr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IF_W-1:0]  inflight_q, inflight_d;
    logic [IF_W-1:0]  discard_q, discard_d;
    logic             stale_q, stale_d;
    logic             held_q, held_d;

    logic [31:0]      mem_pc_q   [DEPTH];
    logic [31:0]      mem_inst_q [DEPTH];

    logic [SUM_W-1:0] occupancy;
    logic             credit_ok;
    logic             req;
    logic [31:0]      addr;
    logic             accept;
    logic             drop;
    logic             push;
    logic             pop;
    logic             head_valid;
    logic             pending_unaccepted;

    // Request side: credits reserve FIFO space for every accepted request.
    always_comb begin
        occupancy          = SUM_W'(inflight_q) + SUM_W'(count_q);
        credit_ok          = (occupancy < SUM_W'(DEPTH)) && (inflight_q < IF_W'(MAX_OUT));
        req                = !reset && (held_q || credit_ok);
        addr               = stale_q ? stale_addr_q : fetch_pc_q;
        accept             = req && inst_addr_ok;
        pending_unaccepted = req && !inst_addr_ok;
        drop               = inst_data_ok && (discard_q != '0);
        push               = inst_data_ok && !drop && !redirect;
        head_valid         = (count_q != '0) && !redirect;
        pop                = head_valid && out_ready;
    end

    always_comb begin
        inflight_d = inflight_q;
        if (accept) begin
            inflight_d = inflight_d + IF_W'(1);
        end
        if (inst_data_ok) begin
            inflight_d = inflight_d - IF_W'(1);
        end
    end

    // Everything already issued when a redirect lands is owed a discard.
    always_comb begin
        discard_d = discard_q;
        if (drop) begin
            discard_d = discard_d - IF_W'(1);
        end
        if (accept && stale_q) begin
            discard_d = discard_d + IF_W'(1);
        end
        if (redirect) begin
            discard_d = inflight_d;
        end
    end

    // A request caught unaccepted by a redirect keeps its old address until taken.
    always_comb begin
        held_d       = pending_unaccepted;
        stale_d      = stale_q;
        stale_addr_d = stale_addr_q;
        if (accept) begin
            stale_d = 1'b0;
        end
        if (redirect && pending_unaccepted) begin
            stale_d      = 1'b1;
            stale_addr_d = addr;
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        if (accept && !stale_q) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
        end
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            stale_q    <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            stale_q    <= stale_d;
            held_q     <= held_d;
        end
    end

    // Storage only; validity is tracked by count_q and stale_q.
    always_ff @(posedge clk) begin
        stale_addr_q <= stale_addr_d;
        if (push) begin
            mem_pc_q[wr_ptr_q]   <= resp_pc_q;
            mem_inst_q[wr_ptr_q] <= inst_rdata;
        end
    end

    assign inst_req  = req;
    assign inst_addr = addr;
    assign out_valid = head_valid;
    assign out_pc    = (count_q != '0) ? mem_pc_q[rd_ptr_q] : 32'd0;
    assign out_inst  = (count_q != '0) ? mem_inst_q[rd_ptr_q] : 32'd0;
    assign inflight  = inflight_q;

    a_no_orphan_data: assert property (@(posedge clk) disable iff (reset)
        inst_data_ok |-> (inflight_q != '0));

    a_credit_bound: assert property (@(posedge clk) disable iff (reset)
        occupancy <= SUM_W'(DEPTH));

    a_held_stable: assert property (@(posedge clk) disable iff (reset)
        (inst_req && !inst_addr_ok) |=> (inst_req && $stable(inst_addr)));

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a bus responder answers one cycle after acceptance,
// and a monitor pops expected PCs whenever decode consumes the FIFO head.
`timescale 1ns/1ps
module tb_fetch_queue;

    localparam logic [31:0] RST_PC = 32'hbfc00000;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;
    logic [1:0]  inflight;

    fetch_queue #(.DEPTH(4), .MAX_OUT(2), .RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_addr_ok(inst_addr_ok),
        .inst_rdata  (inst_rdata),
        .inst_data_ok(inst_data_ok),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_ready   (out_ready),
        .inflight    (inflight)
    );

    int          checks = 0;
    int          errors = 0;
    int          delivered = 0;
    logic        aok_en = 1'b0;
    logic        dok_en = 1'b0;
    logic [31:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_exp(input logic [31:0] base, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(i) * 32'd4);
    endtask

    task automatic wait_delivered(input int target, input string name);
        int n;
        n = 0;
        while (delivered < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(delivered >= target), 32'd1);
    endtask

    // Bus responder: answers each accepted request exactly one cycle later, in order.
    initial begin
        logic [31:0] pend [$];
        logic        last_acc;
        logic        last_dok;
        logic [31:0] last_addr;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'd0;
        last_acc     = 1'b0;
        last_dok     = 1'b0;
        last_addr    = 32'd0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                pend.delete();
                last_acc     = 1'b0;
                last_dok     = 1'b0;
                inst_addr_ok = 1'b0;
                inst_data_ok = 1'b0;
            end else begin
                if (last_dok && pend.size() > 0) void'(pend.pop_front());
                if (last_acc) pend.push_back(last_addr);
                inst_addr_ok = aok_en;
                inst_data_ok = dok_en && (pend.size() > 0);
                inst_rdata   = 32'hdeadbeef;
                if (inst_data_ok) inst_rdata = inst_of(pend[0]);
                last_acc  = inst_req && inst_addr_ok;
                last_addr = inst_addr;
                last_dok  = inst_data_ok;
            end
        end
    end

    // Monitor: every head consumed by decode must match the next expected PC and word.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && out_valid && out_ready) begin
                delivered++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got pc %h, expected no output", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pc", out_pc, e);
                    check("out_inst", out_inst, inst_of(e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d0;
        int          base;
        logic [31:0] x;
        logic [15:0] pat;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        out_ready   = 1'b0;
        load_exp(RST_PC, 64);
        tick(2);

        check("rst_inst_req", 32'(inst_req), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_inst_addr", inst_addr, RST_PC);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_inflight", 32'(inflight), 32'd0);

        // Streaming
        aok_en    = 1'b1;
        dok_en    = 1'b1;
        out_ready = 1'b1;
        reset     = 1'b0;
        tick(1);
        check("startup_not_valid", 32'(out_valid), 32'd0);
        tick(1);
        for (int i = 0; i < 6; i++) begin
            check("stream_valid", 32'(out_valid), 32'd1);
            check("inflight_le_max", 32'(inflight <= 2'd2), 32'd1);
            tick(1);
        end
        wait_delivered(8, "stream_count");

        // Backpressure
        out_ready = 1'b0;
        tick(10);
        check("bp_req_low", 32'(inst_req), 32'd0);
        check("bp_inflight", 32'(inflight), 32'd0);
        check("bp_valid", 32'(out_valid), 32'd1);
        aok_en    = 1'b0;
        d0        = delivered;
        out_ready = 1'b1;
        tick(8);
        check("bp_drained", 32'(delivered - d0), 32'd4);
        check("bp_empty", 32'(out_valid), 32'd0);
        check("bp_resume_req", 32'(inst_req), 32'd1);
        check("bp_resume_addr", inst_addr, RST_PC + 32'(delivered) * 32'd4);

        // Redirect with two requests in flight
        aok_en = 1'b1;
        dok_en = 1'b0;
        tick(5);
        check("rd_inflight2", 32'(inflight), 32'd2);
        check("rd_req_low", 32'(inst_req), 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h80000180;
        load_exp(32'h80000180, 64);
        tick(1);
        check("rd_inflight_kept", 32'(inflight), 32'd2);
        check("rd_fetch_addr", inst_addr, 32'h80000180);
        redirect = 1'b0;
        dok_en   = 1'b1;
        base     = delivered;
        wait_delivered(base + 6, "rd_stream");

        // Redirect while a request is held unaccepted
        aok_en = 1'b0;
        tick(8);
        x = 32'h80000180 + 32'(delivered - base) * 32'd4;
        check("held_req", 32'(inst_req), 32'd1);
        check("held_inflight0", 32'(inflight), 32'd0);
        check("held_empty", 32'(out_valid), 32'd0);
        check("held_addr", inst_addr, x);
        redirect    = 1'b1;
        redirect_pc = 32'h00001000;
        load_exp(32'h00001000, 64);
        tick(1);
        check("held_addr_after_rd", inst_addr, x);
        check("held_req_after_rd", 32'(inst_req), 32'd1);
        redirect = 1'b0;
        tick(2);
        check("held_addr_stable", inst_addr, x);
        aok_en = 1'b1;
        tick(1);
        check("held_next_addr", inst_addr, 32'h00001000);
        check("held_inflight1", 32'(inflight), 32'd1);
        base = delivered;
        wait_delivered(base + 4, "held_stream");

        // Push/pop at full credit, then addr_ok+data_ok+redirect together
        pat = 16'b0010_1110_0100_1101;
        for (int i = 0; i < 16; i++) begin
            out_ready = pat[i];
            tick(1);
        end
        out_ready = 1'b1;
        tick(8);
        check("sim_pre_req", 32'(inst_req), 32'd1);
        check("sim_pre_inflight", 32'(inflight), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h00002000;
        load_exp(32'h00002000, 64);
        tick(1);
        check("sim_inflight", 32'(inflight), 32'd1);
        check("sim_fetch_addr", inst_addr, 32'h00002000);
        redirect = 1'b0;
        base     = delivered;
        wait_delivered(base + 5, "sim_stream");

        // Reset mid-stream with two in flight
        dok_en = 1'b0;
        tick(6);
        check("mrst_inflight2", 32'(inflight), 32'd2);
        reset = 1'b1;
        tick(1);
        check("mrst_req", 32'(inst_req), 32'd0);
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_inflight", 32'(inflight), 32'd0);
        check("mrst_addr", inst_addr, RST_PC);
        check("mrst_out_pc", out_pc, 32'd0);
        load_exp(RST_PC, 64);
        reset  = 1'b0;
        dok_en = 1'b1;
        #1;
        check("mrst_next_req", 32'(inst_req), 32'd1);
        check("mrst_next_addr", inst_addr, RST_PC);
        base = delivered;
        wait_delivered(base + 6, "mrst_stream");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
